vending_ctrl: RTL and testbench

VENDING_CTRL -- requirements
Module: vending_ctrl

---
 rtl/vending_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vending_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// Vending machine controller: accumulates coin credit, sells one of four products,
// returns change and drives the external timer, with every output registered.
module vending_ctrl #(
    parameter int unsigned PRICE0     = 15,
    parameter int unsigned PRICE1     = 20,
    parameter int unsigned PRICE2     = 25,
    parameter int unsigned PRICE3     = 30,
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] coin_in,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    input  logic       timeout_flag,
    output logic [1:0] start_timer,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       dispense,
    output logic [1:0] product_id,
    output logic       change_valid,
    output logic [7:0] change_amt
);

    localparam int unsigned CW = 8;

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_WAIT_SEL = 2'b01;
    localparam logic [1:0] S_DISPENSE = 2'b10;
    localparam logic [1:0] S_CHANGE   = 2'b11;

    localparam logic [1:0] TMR_NONE    = 2'b00;
    localparam logic [1:0] TMR_WAIT    = 2'b01;
    localparam logic [1:0] TMR_PRODUCT = 2'b10;
    localparam logic [1:0] TMR_CHANGE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [1:0]    timer_q, timer_d;
    logic          reject_q, reject_d;
    logic          insuff_q, insuff_d;
    logic          disp_q, disp_d;
    logic [1:0]    pid_q, pid_d;
    logic          chg_valid_q, chg_valid_d;
    logic [CW-1:0] chg_amt_q, chg_amt_d;

    logic [CW-1:0] coin_val;
    logic [CW-1:0] price;
    logic [CW:0]   credit_sum;
    logic          coin_nz;
    logic          coin_fits;

    // Coin decode, selected price and the wrap-free saturation check.
    always_comb begin
        coin_val = '0;
        case (coin_in)
            2'b01:   coin_val = CW'(5);
            2'b10:   coin_val = CW'(10);
            2'b11:   coin_val = CW'(20);
            default: coin_val = '0;
        endcase
        price = '0;
        case (sel_id)
            2'd0:    price = CW'(PRICE0);
            2'd1:    price = CW'(PRICE1);
            2'd2:    price = CW'(PRICE2);
            default: price = CW'(PRICE3);
        endcase
    end

    assign coin_nz    = (coin_in != 2'b00);
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits  = (credit_sum <= (CW+1)'(MAX_CREDIT));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            timer_q     <= TMR_NONE;
            reject_q    <= 1'b0;
            insuff_q    <= 1'b0;
            disp_q      <= 1'b0;
            pid_q       <= 2'b00;
            chg_valid_q <= 1'b0;
            chg_amt_q   <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            timer_q     <= timer_d;
            reject_q    <= reject_d;
            insuff_q    <= insuff_d;
            disp_q      <= disp_d;
            pid_q       <= pid_d;
            chg_valid_q <= chg_valid_d;
            chg_amt_q   <= chg_amt_d;
        end
    end

    // Next state and next outputs; priority cancel > select > timeout > coin.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        timer_d   = TMR_NONE;
        reject_d  = 1'b0;
        insuff_d  = 1'b0;
        pid_d     = pid_q;
        chg_amt_d = chg_amt_q;

        case (state_q)
            S_IDLE: begin
                if (coin_nz) begin
                    if (coin_fits) begin
                        credit_d = credit_sum[CW-1:0];
                        state_d  = S_WAIT_SEL;
                        timer_d  = TMR_WAIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            S_WAIT_SEL: begin
                if (cancel) begin
                    state_d   = S_CHANGE;
                    chg_amt_d = credit_q;
                    timer_d   = TMR_CHANGE;
                    reject_d  = coin_nz;
                end else if (sel_valid) begin
                    reject_d = coin_nz;
                    if (credit_q >= price) begin
                        credit_d = credit_q - price;
                        pid_d    = sel_id;
                        state_d  = S_DISPENSE;
                        timer_d  = TMR_PRODUCT;
                    end else begin
                        insuff_d = 1'b1;
                        timer_d  = TMR_WAIT;
                    end
                end else if (timeout_flag) begin
                    state_d   = S_CHANGE;
                    chg_amt_d = credit_q;
                    timer_d   = TMR_CHANGE;
                    reject_d  = coin_nz;
                end else if (coin_nz) begin
                    if (coin_fits) begin
                        credit_d = credit_sum[CW-1:0];
                        timer_d  = TMR_WAIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            S_DISPENSE: begin
                reject_d = coin_nz;
                if (timeout_flag) begin
                    if (credit_q != '0) begin
                        state_d   = S_CHANGE;
                        chg_amt_d = credit_q;
                        timer_d   = TMR_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                reject_d = coin_nz;
                if (timeout_flag) begin
                    credit_d  = '0;
                    chg_amt_d = '0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Level outputs follow the state being entered so they cover it exactly.
        disp_d      = (state_d == S_DISPENSE);
        chg_valid_d = (state_d == S_CHANGE);
    end

    assign start_timer  = timer_q;
    assign credit       = credit_q;
    assign coin_reject  = reject_q;
    assign insufficient = insuff_q;
    assign dispense     = disp_q;
    assign product_id   = pid_q;
    assign change_valid = chg_valid_q;
    assign change_amt   = chg_amt_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: each directed vector queues its expected
// registered outputs; a monitor pops and compares one entry per clock.
module tb_vending_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] cr;
        logic       rej;
        logic       ins;
        logic       disp;
        logic [1:0] pid;
        logic       cv;
        logic [7:0] camt;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] coin_in;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       timeout_flag;
    logic [1:0] start_timer;
    logic [7:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       dispense;
    logic [1:0] product_id;
    logic       change_valid;
    logic [7:0] change_amt;

    int checks = 0;
    int errors = 0;

    obs_t  exp_q[$];
    string name_q[$];

    vending_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_in      (coin_in),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .timeout_flag (timeout_flag),
        .start_timer  (start_timer),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
        .dispense     (dispense),
        .product_id   (product_id),
        .change_valid (change_valid),
        .change_amt   (change_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t a;
        a = {start_timer, credit, coin_reject, insufficient, dispense,
             product_id, change_valid, change_amt};
        return a;
    endfunction

    function automatic obs_t ob(input logic [1:0] st, input int cr, input bit rej,
                                input bit ins, input bit disp, input logic [1:0] pid,
                                input bit cv, input int camt);
        obs_t o;
        o.st   = st;
        o.cr   = 8'(cr);
        o.rej  = rej;
        o.ins  = ins;
        o.disp = disp;
        o.pid  = pid;
        o.cv   = cv;
        o.camt = 8'(camt);
        return o;
    endfunction

    task automatic report(input string nm, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%b cr=%0d rej=%b ins=%b disp=%b pid=%0d cv=%b camt=%0d, expected st=%b cr=%0d rej=%b ins=%b disp=%b pid=%0d cv=%b camt=%0d",
                     nm, a.st, a.cr, a.rej, a.ins, a.disp, a.pid, a.cv, a.camt,
                     e.st, e.cr, e.rej, e.ins, e.disp, e.pid, e.cv, e.camt);
        end
    endtask

    // Monitor: registered outputs are stable 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            obs_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            report(nm, actual(), e);
        end
    end

    task automatic step(input logic [1:0] coin, input logic sel, input logic [1:0] id,
                        input logic cxl, input logic tmo, input string nm, input obs_t e);
        @(negedge clk);
        coin_in      = coin;
        sel_valid    = sel;
        sel_id       = id;
        cancel       = cxl;
        timeout_flag = tmo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clear_inputs();
        coin_in      = 2'b00;
        sel_valid    = 1'b0;
        sel_id       = 2'b00;
        cancel       = 1'b0;
        timeout_flag = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        report("reset_state", actual(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Purchase with change, plus DISPENSE/CHANGE/IDLE ignore rules.
        step(2'b01, 0, 0, 0, 0, "coin5",          ob(2'b01,  5, 0, 0, 0, 0, 0,  0));
        step(2'b11, 0, 0, 0, 0, "coin20",         ob(2'b01, 25, 0, 0, 0, 0, 0,  0));
        step(2'b00, 1, 0, 0, 0, "sel0",           ob(2'b10, 10, 0, 0, 1, 0, 0,  0));
        step(2'b00, 0, 0, 0, 0, "disp_hold",      ob(2'b00, 10, 0, 0, 1, 0, 0,  0));
        step(2'b10, 0, 0, 0, 0, "disp_coin_rej",  ob(2'b00, 10, 1, 0, 1, 0, 0,  0));
        step(2'b00, 1, 1, 1, 0, "disp_ignore",    ob(2'b00, 10, 0, 0, 1, 0, 0,  0));
        step(2'b00, 0, 0, 0, 1, "disp_to_chg",    ob(2'b11, 10, 0, 0, 0, 0, 1, 10));
        step(2'b00, 0, 0, 0, 0, "chg_hold",       ob(2'b00, 10, 0, 0, 0, 0, 1, 10));
        step(2'b01, 0, 0, 0, 0, "chg_coin_rej",   ob(2'b00, 10, 1, 0, 0, 0, 1, 10));
        step(2'b00, 0, 0, 0, 1, "chg_to_idle",    ob(2'b00,  0, 0, 0, 0, 0, 0,  0));
        step(2'b00, 0, 0, 0, 1, "idle_ign_tmo",   ob(2'b00,  0, 0, 0, 0, 0, 0,  0));
        step(2'b00, 1, 0, 0, 0, "idle_ign_sel",   ob(2'b00,  0, 0, 0, 0, 0, 0,  0));
        step(2'b00, 0, 0, 1, 0, "idle_ign_cxl",   ob(2'b00,  0, 0, 0, 0, 0, 0,  0));

        // Insufficient credit, then timeout refund.
        step(2'b10, 0, 0, 0, 0, "coin10",         ob(2'b01, 10, 0, 0, 0, 0, 0,  0));
        step(2'b00, 1, 3, 0, 0, "insuff_sel3",    ob(2'b01, 10, 0, 1, 0, 0, 0,  0));
        step(2'b00, 0, 0, 0, 1, "wait_tmo",       ob(2'b11, 10, 0, 0, 0, 0, 1, 10));
        step(2'b00, 0, 0, 0, 1, "refund_done",    ob(2'b00,  0, 0, 0, 0, 0, 0,  0));

        // Climb to the ceiling; overflow coins are rejected without re-arming.
        for (int i = 1; i <= 9; i++)
            step(2'b11, 0, 0, 0, 0, $sformatf("climb%0d", i),
                 ob(2'b01, 20 * i, 0, 0, 0, 0, 0, 0));
        step(2'b10, 0, 0, 0, 0, "climb190",       ob(2'b01, 190, 0, 0, 0, 0, 0,   0));
        step(2'b01, 0, 0, 0, 0, "climb195",       ob(2'b01, 195, 0, 0, 0, 0, 0,   0));
        step(2'b10, 0, 0, 0, 0, "over_rej195",    ob(2'b00, 195, 1, 0, 0, 0, 0,   0));
        step(2'b01, 0, 0, 0, 0, "exact_max200",   ob(2'b01, 200, 0, 0, 0, 0, 0,   0));
        step(2'b01, 0, 0, 0, 0, "over_rej200",    ob(2'b00, 200, 1, 0, 0, 0, 0,   0));
        step(2'b11, 1, 2, 0, 0, "sel_wins_coin",  ob(2'b10, 175, 1, 0, 1, 2, 0,   0));
        step(2'b00, 0, 0, 0, 1, "chg175",         ob(2'b11, 175, 0, 0, 0, 2, 1, 175));
        step(2'b00, 0, 0, 0, 1, "idle_after175",  ob(2'b00,   0, 0, 0, 0, 2, 0,   0));

        // Same-cycle priority chains.
        step(2'b11, 0, 0, 0, 0, "prio_coin",      ob(2'b01, 20, 0, 0, 0, 2, 0,  0));
        step(2'b01, 1, 0, 1, 0, "cancel_wins",    ob(2'b11, 20, 1, 0, 0, 2, 1, 20));
        step(2'b00, 0, 0, 0, 1, "cancel_done",    ob(2'b00,  0, 0, 0, 0, 2, 0,  0));
        step(2'b11, 0, 0, 0, 0, "prio_coin2",     ob(2'b01, 20, 0, 0, 0, 2, 0,  0));
        step(2'b00, 1, 3, 0, 1, "sel_over_tmo",   ob(2'b01, 20, 0, 1, 0, 2, 0,  0));
        step(2'b01, 0, 0, 0, 1, "tmo_over_coin",  ob(2'b11, 20, 1, 0, 0, 2, 1, 20));
        step(2'b00, 0, 0, 0, 1, "tmo_done",       ob(2'b00,  0, 0, 0, 0, 2, 0,  0));

        // Exact-price purchase returns straight to IDLE.
        step(2'b11, 0, 0, 0, 0, "exact_coin",     ob(2'b01, 20, 0, 0, 0, 2, 0,  0));
        step(2'b00, 1, 1, 0, 0, "exact_sel1",     ob(2'b10,  0, 0, 0, 1, 1, 0,  0));
        step(2'b00, 0, 0, 0, 1, "exact_to_idle",  ob(2'b00,  0, 0, 0, 0, 1, 0,  0));
        step(2'b00, 0, 0, 0, 0, "exact_no_chg",   ob(2'b00,  0, 0, 0, 0, 1, 0,  0));

        // Asynchronous reset in the middle of DISPENSE.
        step(2'b11, 0, 0, 0, 0, "pre_rst_coin",   ob(2'b01, 20, 0, 0, 0, 1, 0,  0));
        step(2'b01, 0, 0, 0, 0, "pre_rst_coin2",  ob(2'b01, 25, 0, 0, 0, 1, 0,  0));
        step(2'b00, 1, 0, 0, 0, "pre_rst_sel",    ob(2'b10, 10, 0, 0, 1, 0, 0,  0));
        @(posedge clk);
        #3;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        report("async_reset", actual(), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 0, 0, 0, 0, "post_rst_coin",  ob(2'b01,  5, 0, 0, 0, 0, 0,  0));
        step(2'b00, 0, 0, 0, 0, "post_rst_hold",  ob(2'b00,  5, 0, 0, 0, 0, 0,  0));

        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
